// File: rtl/timers_sfr_if.sv
// SFR bus bridge for Timer 0/1: TMOD/TCON storage, shadowed 24-bit loads,
// snapshot-based 24-bit reads and overflow flag management.
module timers_sfr_if #(
   parameter logic [7:0] ADDR_TCON = 8'h88,
   parameter logic [7:0] ADDR_TMOD = 8'h89,
   parameter logic [7:0] ADDR_TL0  = 8'h8A,
   parameter logic [7:0] ADDR_TL1  = 8'h8B,
   parameter logic [7:0] ADDR_TH0  = 8'h8C,
   parameter logic [7:0] ADDR_TH1  = 8'h8D,
   parameter logic [7:0] ADDR_TM0  = 8'hA2,
   parameter logic [7:0] ADDR_TM1  = 8'hA3
) (
   input  logic       timers_sfr_if_machine_cycle_i,
   input  logic       timers_sfr_if_reset_i,
   input  logic [7:0] timers_sfr_if_addr_i,
   input  logic       timers_sfr_if_wr_i,
   input  logic       timers_sfr_if_rd_i,
   input  logic [7:0] timers_sfr_if_wdata_i,
   output logic [7:0] timers_sfr_if_rdata_o,
   output logic       timers_sfr_if_rvalid_o,
   input  logic [7:0] timers_sfr_if_th0_i,
   input  logic [7:0] timers_sfr_if_tm0_i,
   input  logic [7:0] timers_sfr_if_tl0_i,
   input  logic [7:0] timers_sfr_if_th1_i,
   input  logic [7:0] timers_sfr_if_tm1_i,
   input  logic [7:0] timers_sfr_if_tl1_i,
   input  logic       timers_sfr_if_ovf0_i,
   input  logic       timers_sfr_if_ovf1_i,
   input  logic       timers_sfr_if_intack0_i,
   input  logic       timers_sfr_if_intack1_i,
   output logic [7:0] timers_sfr_if_th0_o,
   output logic [7:0] timers_sfr_if_tm0_o,
   output logic [7:0] timers_sfr_if_tl0_o,
   output logic [7:0] timers_sfr_if_th1_o,
   output logic [7:0] timers_sfr_if_tm1_o,
   output logic [7:0] timers_sfr_if_tl1_o,
   output logic       timers_sfr_if_ld0_o,
   output logic       timers_sfr_if_ld1_o,
   output logic       timers_sfr_if_gate_t0_o,
   output logic       timers_sfr_if_m0_t0_o,
   output logic       timers_sfr_if_m1_t0_o,
   output logic       timers_sfr_if_gate_t1_o,
   output logic       timers_sfr_if_m0_t1_o,
   output logic       timers_sfr_if_m1_t1_o,
   output logic       timers_sfr_if_tr0_o,
   output logic       timers_sfr_if_tf0_o,
   output logic       timers_sfr_if_tr1_o,
   output logic       timers_sfr_if_tf1_o
);

   logic       clk;
   logic       rst;
   logic [7:0] addr;
   logic       wr;
   logic       rd;
   logic [7:0] wdata;
   logic       tcon_wr;

   logic [7:0] tmod_q, tmod_d;
   logic [7:0] tcon_q, tcon_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rvalid_q, rvalid_d;

   logic [7:0] shadow_h0_q, shadow_h0_d;
   logic [7:0] shadow_m0_q, shadow_m0_d;
   logic [7:0] shadow_h1_q, shadow_h1_d;
   logic [7:0] shadow_m1_q, shadow_m1_d;

   logic [7:0] snap0_h_q, snap0_h_d;
   logic [7:0] snap0_m_q, snap0_m_d;
   logic [7:0] snap1_h_q, snap1_h_d;
   logic [7:0] snap1_m_q, snap1_m_d;

   logic [7:0] th0_q, th0_d;
   logic [7:0] tm0_q, tm0_d;
   logic [7:0] tl0_q, tl0_d;
   logic [7:0] th1_q, th1_d;
   logic [7:0] tm1_q, tm1_d;
   logic [7:0] tl1_q, tl1_d;
   logic       ld0_q, ld0_d;
   logic       ld1_q, ld1_d;

   assign clk     = timers_sfr_if_machine_cycle_i;
   assign rst     = timers_sfr_if_reset_i;
   assign addr    = timers_sfr_if_addr_i;
   assign wr      = timers_sfr_if_wr_i;
   assign rd      = timers_sfr_if_rd_i;
   assign wdata   = timers_sfr_if_wdata_i;
   assign tcon_wr = wr && (addr == ADDR_TCON);

   always_comb begin
      tmod_d      = tmod_q;
      tcon_d      = tcon_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      shadow_h0_d = shadow_h0_q;
      shadow_m0_d = shadow_m0_q;
      shadow_h1_d = shadow_h1_q;
      shadow_m1_d = shadow_m1_q;
      snap0_h_d   = snap0_h_q;
      snap0_m_d   = snap0_m_q;
      snap1_h_d   = snap1_h_q;
      snap1_m_d   = snap1_m_q;
      th0_d       = th0_q;
      tm0_d       = tm0_q;
      tl0_d       = tl0_q;
      th1_d       = th1_q;
      tm1_d       = tm1_q;
      tl1_d       = tl1_q;
      ld0_d       = 1'b0;
      ld1_d       = 1'b0;

      // Read path uses pre-write register values, so a same-cycle write is not visible.
      if (rd) begin
         rvalid_d = 1'b1;
         case (addr)
            ADDR_TCON: rdata_d = tcon_q;
            ADDR_TMOD: rdata_d = tmod_q;
            ADDR_TL0: begin
               rdata_d   = timers_sfr_if_tl0_i;
               snap0_h_d = timers_sfr_if_th0_i;
               snap0_m_d = timers_sfr_if_tm0_i;
            end
            ADDR_TL1: begin
               rdata_d   = timers_sfr_if_tl1_i;
               snap1_h_d = timers_sfr_if_th1_i;
               snap1_m_d = timers_sfr_if_tm1_i;
            end
            ADDR_TH0:  rdata_d = snap0_h_q;
            ADDR_TM0:  rdata_d = snap0_m_q;
            ADDR_TH1:  rdata_d = snap1_h_q;
            ADDR_TM1:  rdata_d = snap1_m_q;
            default:   rdata_d = 8'h00;
         endcase
      end

      if (wr) begin
         case (addr)
            ADDR_TCON: tcon_d      = wdata;
            ADDR_TMOD: tmod_d      = wdata;
            ADDR_TH0:  shadow_h0_d = wdata;
            ADDR_TM0:  shadow_m0_d = wdata;
            ADDR_TH1:  shadow_h1_d = wdata;
            ADDR_TM1:  shadow_m1_d = wdata;
            ADDR_TL0: begin
               th0_d = shadow_h0_q;
               tm0_d = shadow_m0_q;
               tl0_d = wdata;
               ld0_d = 1'b1;
            end
            ADDR_TL1: begin
               th1_d = shadow_h1_q;
               tm1_d = shadow_m1_q;
               tl1_d = wdata;
               ld1_d = 1'b1;
            end
            default: ;
         endcase
      end

      // Overflow beats a CPU write, which beats interrupt acknowledge.
      if (timers_sfr_if_ovf0_i) begin
         tcon_d[5] = 1'b1;
      end else if (!tcon_wr && timers_sfr_if_intack0_i) begin
         tcon_d[5] = 1'b0;
      end
      if (timers_sfr_if_ovf1_i) begin
         tcon_d[7] = 1'b1;
      end else if (!tcon_wr && timers_sfr_if_intack1_i) begin
         tcon_d[7] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmod_q      <= 8'h00;
         tcon_q      <= 8'h00;
         rdata_q     <= 8'h00;
         rvalid_q    <= 1'b0;
         shadow_h0_q <= 8'h00;
         shadow_m0_q <= 8'h00;
         shadow_h1_q <= 8'h00;
         shadow_m1_q <= 8'h00;
         snap0_h_q   <= 8'h00;
         snap0_m_q   <= 8'h00;
         snap1_h_q   <= 8'h00;
         snap1_m_q   <= 8'h00;
         th0_q       <= 8'h00;
         tm0_q       <= 8'h00;
         tl0_q       <= 8'h00;
         th1_q       <= 8'h00;
         tm1_q       <= 8'h00;
         tl1_q       <= 8'h00;
         ld0_q       <= 1'b0;
         ld1_q       <= 1'b0;
      end else begin
         tmod_q      <= tmod_d;
         tcon_q      <= tcon_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         shadow_h0_q <= shadow_h0_d;
         shadow_m0_q <= shadow_m0_d;
         shadow_h1_q <= shadow_h1_d;
         shadow_m1_q <= shadow_m1_d;
         snap0_h_q   <= snap0_h_d;
         snap0_m_q   <= snap0_m_d;
         snap1_h_q   <= snap1_h_d;
         snap1_m_q   <= snap1_m_d;
         th0_q       <= th0_d;
         tm0_q       <= tm0_d;
         tl0_q       <= tl0_d;
         th1_q       <= th1_d;
         tm1_q       <= tm1_d;
         tl1_q       <= tl1_d;
         ld0_q       <= ld0_d;
         ld1_q       <= ld1_d;
      end
   end

   assign timers_sfr_if_rdata_o   = rdata_q;
   assign timers_sfr_if_rvalid_o  = rvalid_q;
   assign timers_sfr_if_th0_o     = th0_q;
   assign timers_sfr_if_tm0_o     = tm0_q;
   assign timers_sfr_if_tl0_o     = tl0_q;
   assign timers_sfr_if_th1_o     = th1_q;
   assign timers_sfr_if_tm1_o     = tm1_q;
   assign timers_sfr_if_tl1_o     = tl1_q;
   assign timers_sfr_if_ld0_o     = ld0_q;
   assign timers_sfr_if_ld1_o     = ld1_q;
   assign timers_sfr_if_gate_t1_o = tmod_q[7];
   assign timers_sfr_if_m1_t1_o   = tmod_q[5];
   assign timers_sfr_if_m0_t1_o   = tmod_q[4];
   assign timers_sfr_if_gate_t0_o = tmod_q[3];
   assign timers_sfr_if_m1_t0_o   = tmod_q[1];
   assign timers_sfr_if_m0_t0_o   = tmod_q[0];
   assign timers_sfr_if_tf1_o     = tcon_q[7];
   assign timers_sfr_if_tr1_o     = tcon_q[6];
   assign timers_sfr_if_tf0_o     = tcon_q[5];
   assign timers_sfr_if_tr0_o     = tcon_q[4];

endmodule

// File: tb/tb_timers_sfr_if.sv
// Bench for timers_sfr_if: directed scenarios followed by random bus traffic,
// every cycle compared against an array-based reference model.
module tb_timers_sfr_if;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addr;
   logic       wr;
   logic       rd;
   logic [7:0] wdata;
   logic       ovf0, ovf1, intack0, intack1;
   logic [23:0] cnt0, cnt1;

   logic [7:0] rdata;
   logic       rvalid;
   logic [7:0] th0_o, tm0_o, tl0_o, th1_o, tm1_o, tl1_o;
   logic       ld0, ld1;
   logic       gate_t0, m0_t0, m1_t0, gate_t1, m0_t1, m1_t1;
   logic       tr0, tf0, tr1, tf1;

   always #5 clk = ~clk;

   timers_sfr_if dut (
      .timers_sfr_if_machine_cycle_i(clk),
      .timers_sfr_if_reset_i(rst),
      .timers_sfr_if_addr_i(addr),
      .timers_sfr_if_wr_i(wr),
      .timers_sfr_if_rd_i(rd),
      .timers_sfr_if_wdata_i(wdata),
      .timers_sfr_if_rdata_o(rdata),
      .timers_sfr_if_rvalid_o(rvalid),
      .timers_sfr_if_th0_i(cnt0[23:16]),
      .timers_sfr_if_tm0_i(cnt0[15:8]),
      .timers_sfr_if_tl0_i(cnt0[7:0]),
      .timers_sfr_if_th1_i(cnt1[23:16]),
      .timers_sfr_if_tm1_i(cnt1[15:8]),
      .timers_sfr_if_tl1_i(cnt1[7:0]),
      .timers_sfr_if_ovf0_i(ovf0),
      .timers_sfr_if_ovf1_i(ovf1),
      .timers_sfr_if_intack0_i(intack0),
      .timers_sfr_if_intack1_i(intack1),
      .timers_sfr_if_th0_o(th0_o),
      .timers_sfr_if_tm0_o(tm0_o),
      .timers_sfr_if_tl0_o(tl0_o),
      .timers_sfr_if_th1_o(th1_o),
      .timers_sfr_if_tm1_o(tm1_o),
      .timers_sfr_if_tl1_o(tl1_o),
      .timers_sfr_if_ld0_o(ld0),
      .timers_sfr_if_ld1_o(ld1),
      .timers_sfr_if_gate_t0_o(gate_t0),
      .timers_sfr_if_m0_t0_o(m0_t0),
      .timers_sfr_if_m1_t0_o(m1_t0),
      .timers_sfr_if_gate_t1_o(gate_t1),
      .timers_sfr_if_m0_t1_o(m0_t1),
      .timers_sfr_if_m1_t1_o(m1_t1),
      .timers_sfr_if_tr0_o(tr0),
      .timers_sfr_if_tf0_o(tf0),
      .timers_sfr_if_tr1_o(tr1),
      .timers_sfr_if_tf1_o(tf1)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: index 0/1 selects the timer.
   logic [7:0]  m_tmod, m_tcon, m_rdata;
   logic        m_rvalid;
   logic [7:0]  m_sh_h[2], m_sh_m[2], m_sn_h[2], m_sn_m[2];
   logic [7:0]  m_ld_h[2], m_ld_m[2], m_ld_l[2];
   logic        m_ld[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_update();
      logic [23:0] live[2];
      logic        ovf[2];
      logic        ack[2];
      logic        tcon_write;
      live[0] = cnt0;  live[1] = cnt1;
      ovf[0]  = ovf0;  ovf[1]  = ovf1;
      ack[0]  = intack0; ack[1] = intack1;
      if (rst) begin
         m_tmod = 0; m_tcon = 0; m_rdata = 0; m_rvalid = 0;
         for (int x = 0; x < 2; x++) begin
            m_sh_h[x] = 0; m_sh_m[x] = 0; m_sn_h[x] = 0; m_sn_m[x] = 0;
            m_ld_h[x] = 0; m_ld_m[x] = 0; m_ld_l[x] = 0; m_ld[x] = 0;
         end
         return;
      end
      m_rvalid = rd;
      if (rd) begin
         m_rdata = 8'h00;
         if (addr == 8'h88) m_rdata = m_tcon;
         if (addr == 8'h89) m_rdata = m_tmod;
         for (int x = 0; x < 2; x++) begin
            if (addr == 8'h8C + x) m_rdata = m_sn_h[x];
            if (addr == 8'hA2 + x) m_rdata = m_sn_m[x];
            if (addr == 8'h8A + x) begin
               m_rdata  = live[x][7:0];
               m_sn_h[x] = live[x][23:16];
               m_sn_m[x] = live[x][15:8];
            end
         end
      end
      tcon_write = wr && addr == 8'h88;
      for (int x = 0; x < 2; x++) begin
         m_ld[x] = 1'b0;
         if (wr && addr == 8'h8C + x) m_sh_h[x] = wdata;
         if (wr && addr == 8'hA2 + x) m_sh_m[x] = wdata;
         if (wr && addr == 8'h8A + x) begin
            m_ld[x]   = 1'b1;
            m_ld_h[x] = m_sh_h[x];
            m_ld_m[x] = m_sh_m[x];
            m_ld_l[x] = wdata;
         end
      end
      if (wr && addr == 8'h89) m_tmod = wdata;
      if (tcon_write) m_tcon = wdata;
      for (int x = 0; x < 2; x++) begin
         if (ovf[x]) m_tcon[5 + 2 * x] = 1'b1;
         else if (!tcon_write && ack[x]) m_tcon[5 + 2 * x] = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("rdata", rdata, m_rdata);
      chk("rvalid", rvalid, m_rvalid);
      chk("tmod_fields", {gate_t1, m1_t1, m0_t1, gate_t0, m1_t0, m0_t0},
          {m_tmod[7], m_tmod[5], m_tmod[4], m_tmod[3], m_tmod[1], m_tmod[0]});
      chk("tcon_bits", {tf1, tr1, tf0, tr0}, m_tcon[7:4]);
      chk("load0", {ld0, th0_o, tm0_o, tl0_o}, {m_ld[0], m_ld_h[0], m_ld_m[0], m_ld_l[0]});
      chk("load1", {ld1, th1_o, tm1_o, tl1_o}, {m_ld[1], m_ld_h[1], m_ld_m[1], m_ld_l[1]});
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic idle();
      rst = 0; wr = 0; rd = 0; addr = 8'h00; wdata = 8'h00;
      ovf0 = 0; ovf1 = 0; intack0 = 0; intack1 = 0;
   endtask

   task automatic bus(input logic [7:0] a, input logic w, input logic r, input logic [7:0] d);
      idle();
      addr = a; wr = w; rd = r; wdata = d;
   endtask

   logic [7:0] addr_tab[10];

   initial begin
      addr_tab = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'hA2, 8'hA3, 8'h00, 8'hFF};
      cnt0 = 24'h0; cnt1 = 24'h0;
      idle();
      rst = 1;
      step();
      step();
      chk("reset_outputs", {rdata, rvalid, ld0, ld1, tf0, tf1, tr0, tr1, gate_t0, gate_t1}, 0);

      bus(8'h89, 0, 1, 0); step();
      chk("rd_tmod_rst", {rvalid, rdata}, {1'b1, 8'h00});
      bus(8'h88, 0, 1, 0); step();
      bus(8'h8A, 0, 1, 0); step();
      idle(); step();
      chk("rvalid_pulse", rvalid, 1'b0);

      bus(8'h89, 1, 0, 8'hA9); step();
      chk("tmod_a9", {gate_t1, m1_t1, m0_t1, gate_t0, m1_t0, m0_t0}, 6'b110101);
      bus(8'h89, 0, 1, 0); step();
      chk("tmod_rb", rdata, 8'hA9);

      bus(8'h8C, 1, 0, 8'h12); step();
      chk("no_ld_th", ld0, 1'b0);
      bus(8'hA2, 1, 0, 8'h34); step();
      chk("no_ld_tm", ld0, 1'b0);
      bus(8'h8A, 1, 0, 8'h56); step();
      chk("ld0_val", {ld0, th0_o, tm0_o, tl0_o}, {1'b1, 24'h123456});
      idle(); step();
      chk("ld0_once", ld0, 1'b0);

      cnt0 = 24'h01FFFF;
      bus(8'h8A, 0, 1, 0); step();
      chk("snap_tl", rdata, 8'hFF);
      cnt0 = 24'h020003;
      bus(8'hA2, 0, 1, 0); step();
      chk("snap_tm", rdata, 8'hFF);
      bus(8'h8C, 0, 1, 0); step();
      chk("snap_th", rdata, 8'h01);

      idle(); ovf0 = 1; step();
      chk("tf0_set", tf0, 1'b1);
      bus(8'h88, 1, 0, 8'h00); ovf0 = 1; step();
      chk("tf0_ovf_wins", tf0, 1'b1);
      idle(); intack0 = 1; step();
      chk("tf0_ack", tf0, 1'b0);

      bus(8'h8C, 1, 0, 8'hAB); step();
      idle(); rst = 1; step();
      chk("rst_no_ld", ld0, 1'b0);
      bus(8'h8A, 1, 0, 8'h77); step();
      chk("ld0_after_rst", {ld0, th0_o, tm0_o, tl0_o}, {1'b1, 24'h000077});

      bus(8'h88, 1, 1, 8'h5A); step();
      chk("rw_same_cycle", {rvalid, rdata}, {1'b1, 8'h00});

      for (int i = 0; i < 3000; i++) begin
         idle();
         addr  = addr_tab[$urandom_range(9)];
         wr    = ($urandom_range(2) == 0);
         rd    = ($urandom_range(1) == 0);
         wdata = 8'($urandom);
         ovf0    = ($urandom_range(7) == 0);
         ovf1    = ($urandom_range(7) == 0);
         intack0 = ($urandom_range(5) == 0);
         intack1 = ($urandom_range(5) == 0);
         rst     = ($urandom_range(99) == 0);
         if ($urandom_range(3) == 0) cnt0 = 24'($urandom);
         if ($urandom_range(3) == 0) cnt1 = 24'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
